// File: rtl/ps2_key_event_decoder.sv
// Polls a PS/2 core data register over Avalon-MM and decodes scan-code set 2 byte
// sequences into make/break key events, buffered in a show-ahead FIFO.
module ps2_key_event_decoder #(
    parameter int POLL_INTERVAL = 1000,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic                          m_chipselect,
    output logic                          m_read,
    output logic                          m_address,
    output logic [3:0]                    m_byteenable,
    input  logic [31:0]                   m_readdata,
    input  logic                          m_waitrequest,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(POLL_INTERVAL);
    localparam logic [TW-1:0] RELOAD     = TW'(POLL_INTERVAL - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    logic [0:0]    state;
    logic [TW-1:0] timer;
    logic          ext_flag, brk_flag;
    logic [2:0]    skip_cnt;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [9:0]    head_hold;

    logic [7:0]    rx_byte;
    logic          rvalid, ravail_nz, sample, is_noise;
    logic          full, full_after, push, push_fire, pop;
    logic [9:0]    push_evt;
    logic          nxt_ext, nxt_brk;
    logic [2:0]    nxt_skip;
    logic [AW:0]   count_next;

    // Decoding m_read from the async-reset state register makes it drop the instant reset_n falls.
    assign m_read       = (state == ST_READ);
    assign m_chipselect = m_read;
    assign m_address    = 1'b0;
    assign m_byteenable = 4'b1111;

    assign rx_byte   = m_readdata[7:0];
    assign rvalid    = m_readdata[15];
    assign ravail_nz = |m_readdata[31:16];
    assign sample    = m_read && !m_waitrequest && rvalid;
    assign is_noise  = rx_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        push     = 1'b0;
        push_evt = {ext_flag, brk_flag, rx_byte};
        nxt_ext  = ext_flag;
        nxt_brk  = brk_flag;
        nxt_skip = skip_cnt;
        if (sample) begin
            if (skip_cnt != 3'd0) begin
                nxt_skip = skip_cnt - 3'd1;
            end else if (rx_byte == 8'hE1) begin
                // Pause key: report once, then swallow the remaining 7 bytes of the sequence.
                push     = 1'b1;
                push_evt = {1'b1, 1'b0, 8'hE1};
                nxt_skip = 3'd7;
                nxt_ext  = 1'b0;
                nxt_brk  = 1'b0;
            end else if (rx_byte == 8'hE0) begin
                nxt_ext = 1'b1;
            end else if (rx_byte == 8'hF0) begin
                nxt_brk = 1'b1;
            end else if (!(is_noise && !ext_flag && !brk_flag)) begin
                push    = 1'b1;
                nxt_ext = 1'b0;
                nxt_brk = 1'b0;
            end
        end
    end

    assign full       = (count == FULL_COUNT);
    assign evt_valid  = (count != '0);
    assign pop        = evt_valid && evt_ready;
    assign push_fire  = push && (!full || pop);
    assign count_next = count + {{AW{1'b0}}, push_fire} - {{AW{1'b0}}, pop};
    assign full_after = (count_next == FULL_COUNT);
    assign fifo_count = count;

    assign {evt_ext, evt_break, evt_code} = evt_valid ? mem[rd_ptr] : head_hold;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            timer <= RELOAD;
        end else if (state == ST_IDLE) begin
            if (timer != '0) begin
                timer <= timer - TW'(1);
            end else if (!full) begin
                state <= ST_READ;
            end
        end else if (!m_waitrequest) begin
            // Keep draining back-to-back only while the core reports more bytes and room remains.
            if (!(rvalid && ravail_nz && !full_after)) begin
                state <= ST_IDLE;
                timer <= RELOAD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            skip_cnt <= 3'd0;
        end else begin
            ext_flag <= nxt_ext;
            brk_flag <= nxt_brk;
            skip_cnt <= nxt_skip;
        end
    end

    // NOTE: the storage array is not reset; only pointers and count qualify its contents.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_evt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_hold <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + AW'(1);
            if (pop)       rd_ptr <= rd_ptr + AW'(1);
            if (evt_valid) head_hold <= mem[rd_ptr];
            count <= count_next;
        end
    end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Self-checking bench: an Avalon slave model feeds bytes from a queue, expected events
// go to a scoreboard queue and are compared as the consumer pops them.
`timescale 1ns/1ps
module tb_ps2_key_event_decoder;

    localparam int P     = 20;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset_n;
    logic          m_chipselect, m_read, m_address;
    logic [3:0]    m_byteenable;
    logic [31:0]   m_readdata;
    logic          m_waitrequest;
    logic          evt_valid, evt_ready;
    logic [7:0]    evt_code;
    logic          evt_ext, evt_break;
    logic [CW-1:0] fifo_count;

    ps2_key_event_decoder #(.POLL_INTERVAL(P), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m_chipselect (m_chipselect),
        .m_read       (m_read),
        .m_address    (m_address),
        .m_byteenable (m_byteenable),
        .m_readdata   (m_readdata),
        .m_waitrequest(m_waitrequest),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_ext      (evt_ext),
        .evt_break    (evt_break),
        .fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       has_evt;
        logic [9:0] evt;   // {ext, brk, code}
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] slave_q[$];
    logic [9:0] exp_q[$];
    logic       slave_take;
    vec_t       vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic h, input logic [9:0] e);
        vec_t v;
        v.b       = b;
        v.has_evt = h;
        v.evt     = e;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while ((slave_q.size() != 0 || exp_q.size() != 0) && cyc < 60 * P) begin
            step();
            cyc++;
        end
        repeat (3) step();
        check({name, "_events_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_bytes_left"}, 32'(slave_q.size()), 32'd0);
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (m_read && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("wait_idle", 32'(m_read), 32'd0);
    endtask

    // Avalon slave: RVALID when bytes are queued, RAVAIL = bytes left behind the current one.
    initial begin
        m_readdata = '0;
        forever begin
            @(negedge clk);
            slave_take = m_read && !m_waitrequest && m_readdata[15];
            @(posedge clk);
            #2;
            if (slave_take && slave_q.size() > 0) void'(slave_q.pop_front());
            if (slave_q.size() > 0)
                m_readdata = {16'(slave_q.size() - 1), 1'b1, 7'b0, slave_q[0]};
            else
                m_readdata = '0;
        end
    end

    // Consumer-side scoreboard and chipselect/read equivalence.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            check("cs_eq_read", 32'(m_chipselect), 32'(m_read));
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_evt actual=%0h required=none",
                             {evt_ext, evt_break, evt_code});
                end else begin
                    e = exp_q.pop_front();
                    check("evt", 32'({evt_ext, evt_break, evt_code}), 32'(e));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, run, found, ev_seen;
        int idx[$];

        vecs[0]  = mk(8'h1C, 1'b1, {2'b00, 8'h1C});
        vecs[1]  = mk(8'hF0, 1'b0, '0);
        vecs[2]  = mk(8'h1C, 1'b1, {2'b01, 8'h1C});
        vecs[3]  = mk(8'hFA, 1'b0, '0);
        vecs[4]  = mk(8'hAA, 1'b0, '0);
        vecs[5]  = mk(8'hE0, 1'b0, '0);
        vecs[6]  = mk(8'h6B, 1'b1, {2'b10, 8'h6B});
        vecs[7]  = mk(8'hE0, 1'b0, '0);
        vecs[8]  = mk(8'hF0, 1'b0, '0);
        vecs[9]  = mk(8'h6B, 1'b1, {2'b11, 8'h6B});
        vecs[10] = mk(8'hF0, 1'b0, '0);
        vecs[11] = mk(8'hFF, 1'b1, {2'b01, 8'hFF});
        vecs[12] = mk(8'hEE, 1'b0, '0);
        vecs[13] = mk(8'hE1, 1'b1, {2'b10, 8'hE1});
        vecs[14] = mk(8'h14, 1'b0, '0);
        vecs[15] = mk(8'h77, 1'b0, '0);
        vecs[16] = mk(8'hE1, 1'b0, '0);
        vecs[17] = mk(8'hF0, 1'b0, '0);
        vecs[18] = mk(8'h14, 1'b0, '0);
        vecs[19] = mk(8'hF0, 1'b0, '0);
        vecs[20] = mk(8'h77, 1'b0, '0);
        vecs[21] = mk(8'h1C, 1'b1, {2'b00, 8'h1C});
        vecs[22] = mk(8'h00, 1'b0, '0);
        vecs[23] = mk(8'hFE, 1'b0, '0);
        vecs[24] = mk(8'hE0, 1'b0, '0);
        vecs[25] = mk(8'h00, 1'b1, {2'b10, 8'h00});

        reset_n       = 1'b0;
        m_waitrequest = 1'b0;
        evt_ready     = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_read", 32'(m_read), 32'd0);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_evt", 32'({evt_ext, evt_break, evt_code}), 32'd0);
        check("rst_addr_be", 32'({m_address, m_byteenable}), 32'h0F);
        reset_n = 1'b1;

        // Idle polling with an empty slave
        n = 0;
        for (int i = 0; i < 4 * P; i++) begin
            @(negedge clk);
            n++;
            if (m_read) break;
        end
        check("first_poll_latency", 32'(n), 32'(P + 1));
        ev_seen = 0;
        for (int i = 1; i <= 3 * (P + 1); i++) begin
            @(negedge clk);
            if (m_read) idx.push_back(i);
            if (evt_valid) ev_seen++;
        end
        check("poll_pulses", 32'(idx.size()), 32'd3);
        for (int k = 0; k < idx.size() && k < 3; k++)
            check("poll_period", 32'(idx[k]), 32'((k + 1) * (P + 1)));
        check("idle_no_events", 32'(ev_seen), 32'd0);

        // Decode table
        step();
        for (int i = 0; i < 26; i++) begin
            slave_q.push_back(vecs[i].b);
            if (vecs[i].has_evt) exp_q.push_back(vecs[i].evt);
        end
        drain("table");
        check("evt_hold_after_pop", 32'({evt_ext, evt_break, evt_code}), 32'({2'b10, 8'h00}));

        // E0 F0 75 drained back-to-back
        wait_idle();
        step();
        slave_q.push_back(8'hE0);
        slave_q.push_back(8'hF0);
        slave_q.push_back(8'h75);
        exp_q.push_back({2'b11, 8'h75});
        found = 0;
        for (int i = 0; i < 4 * P; i++) begin
            @(negedge clk);
            if (m_read) begin found = 1; break; end
        end
        check("burst_start", 32'(found), 32'd1);
        run = 0;
        while (m_read && run < 20) begin
            run++;
            @(negedge clk);
        end
        check("burst_len", 32'(run), 32'd3);
        drain("burst");

        // Back-pressure: 9 make codes into an 8-deep FIFO
        step();
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            slave_q.push_back(8'h15 + 8'(i));
            exp_q.push_back({2'b00, 8'h15 + 8'(i)});
        end
        n = 0;
        while (fifo_count != CW'(DEPTH) && n < 20 * P) begin
            @(negedge clk);
            n++;
        end
        check("full_count", 32'(fifo_count), 32'(DEPTH));
        hi = 0;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            if (m_read) hi++;
        end
        check("no_read_when_full", 32'(hi), 32'd0);
        check("byte_waiting", 32'(slave_q.size()), 32'd1);
        check("full_head", 32'({evt_valid, evt_ext, evt_break, evt_code}), 32'({3'b100, 8'h15}));
        step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_read) begin found = 1; break; end
        end
        check("read_after_pop", 32'(found), 32'd1);
        n = 0;
        while (fifo_count != CW'(DEPTH) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("refill_count", 32'(fifo_count), 32'(DEPTH));
        check("ninth_byte_taken", 32'(slave_q.size()), 32'd0);
        step();
        evt_ready = 1'b1;
        drain("backpressure");

        // Reset during a stalled read leaves no stale prefix flags
        step();
        slave_q.push_back(8'hE0);
        slave_q.push_back(8'hF0);
        drain("prefix");
        wait_idle();
        step();
        m_waitrequest = 1'b1;
        slave_q.push_back(8'h1C);
        found = 0;
        for (int i = 0; i < 4 * P; i++) begin
            @(negedge clk);
            if (m_read) begin found = 1; break; end
        end
        check("stall_read_start", 32'(found), 32'd1);
        repeat (5) @(posedge clk);
        #3;
        check("read_held", 32'(m_read), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_read", 32'(m_read), 32'd0);
        check("rst_mid_cs", 32'(m_chipselect), 32'd0);
        check("rst_mid_valid", 32'(evt_valid), 32'd0);
        check("rst_mid_count", 32'(fifo_count), 32'd0);
        check("rst_mid_evt", 32'({evt_ext, evt_break, evt_code}), 32'd0);
        step();
        m_waitrequest = 1'b0;
        reset_n       = 1'b1;
        exp_q.push_back({2'b00, 8'h1C});
        drain("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
